axi_rd_responder: RTL and testbench

- AXI4 read-channel subordinate (AR/R) that serves read bursts from the CVA6 data/fetch master out of a synchronous single-port SRAM.
- Used as the far end of the core's AXI read path: a boot ROM/scratchpad model in the testbench, or an on-chip memory in small SoCs.
- Handles FIXED, INCR and WRAP bursts and narrow sizes.
- Sustains one R beat per cycle under no backpressure.

---
 rtl/axi_rd_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_axi_rd_responder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_responder.sv
// AXI4 read-channel subordinate (AR/R) backed by a synchronous single-port SRAM.
// Serves FIXED/INCR/WRAP bursts of any legal size; narrow beats return the
// full SRAM word and the master picks lanes. A 2-entry R buffer plus an issue
// throttle lets R run one beat per cycle without ever overflowing.
//
// Handshake rule on AR and R: a transfer happens on a rising clock edge where
// valid and ready are both 1. valid never waits on ready, and once r_valid_o is
// raised the R payload (id/data/resp/last) holds steady until it transfers.
module axi_rd_responder #(
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter logic [63:0] MemBase      = 64'h8000_0000,
  parameter int unsigned MemWords     = 4096
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        ar_valid_i,
  output logic                        ar_ready_o,
  input  logic [AxiIdWidth-1:0]       ar_id_i,
  input  logic [AxiAddrWidth-1:0]     ar_addr_i,
  input  logic [7:0]                  ar_len_i,
  input  logic [2:0]                  ar_size_i,
  input  logic [1:0]                  ar_burst_i,
  output logic                        r_valid_o,
  input  logic                        r_ready_i,
  output logic [AxiIdWidth-1:0]       r_id_o,
  output logic [AxiDataWidth-1:0]     r_data_o,
  output logic [1:0]                  r_resp_o,
  output logic                        r_last_o,
  output logic                        mem_req_o,
  output logic [$clog2(MemWords)-1:0] mem_addr_o,
  input  logic [AxiDataWidth-1:0]     mem_rdata_i
);

  localparam int unsigned IdxW = $clog2(MemWords);
  localparam int unsigned OffW = $clog2(AxiDataWidth / 8);
  localparam logic [2:0]  MaxSize = 3'(OffW);
  localparam logic [AxiAddrWidth-1:0] WinBase  = AxiAddrWidth'(MemBase);
  localparam logic [AxiAddrWidth-1:0] WinBytes = AxiAddrWidth'(MemWords) << OffW;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBurst = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  function automatic logic in_window(input logic [AxiAddrWidth-1:0] a);
    return (a >= WinBase) && ((a - WinBase) < WinBytes);
  endfunction

  // FSM and latched burst context
  logic [1:0]              state_q, state_d;
  logic [AxiIdWidth-1:0]   id_q;
  logic [AxiAddrWidth-1:0] addr_q, addr_d;
  logic [7:0]              len_q;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    burst_err_q;

  // Beat issued last cycle whose SRAM data is arriving now
  logic infl_q, infl_err_q, infl_last_q;

  // R buffer
  logic [AxiDataWidth-1:0] fifo_data_q [2];
  logic [1:0]              fifo_err_q, fifo_last_q;
  logic                    rd_ptr_q, wr_ptr_q;
  logic [1:0]              fifo_cnt_q, fifo_cnt_d;

  logic                    ar_hs, ar_err;
  logic                    issue, beat_err, last_issue;
  logic                    head_fifo, r_hs, push, pop;
  logic [1:0]              slots_used;
  logic [AxiAddrWidth-1:0] step, bound, addr_incr, addr_next;
  logic [AxiDataWidth-1:0] beat_data;

  assign ar_ready_o = (state_q == StIdle);
  assign ar_hs      = ar_valid_i && ar_ready_o;

  // Whole-burst error classification, evaluated on the live AR fields
  always_comb begin
    ar_err = 1'b0;
    if (ar_size_i > MaxSize) ar_err = 1'b1;
    if (ar_burst_i == 2'b11) ar_err = 1'b1;
    if ((ar_burst_i == BurstWrap) &&
        !(ar_len_i inside {8'd1, 8'd3, 8'd7, 8'd15})) ar_err = 1'b1;
    if (!in_window(ar_addr_i)) ar_err = 1'b1;
  end

  // Issue throttle: buffered + in-flight beats never exceed the two buffer slots
  assign slots_used = fifo_cnt_q + {1'b0, infl_q};
  assign issue      = (state_q == StBurst) && (slots_used < 2'd2);
  assign last_issue = issue && (beat_cnt_q == 8'd0);
  assign beat_err   = burst_err_q || ((burst_q == BurstIncr) && !in_window(addr_q));
  assign mem_req_o  = issue && !beat_err;
  assign mem_addr_o = IdxW'((addr_q - WinBase) >> OffW);

  // Next beat address for the three burst types
  always_comb begin
    step      = AxiAddrWidth'(1) << size_q;
    bound     = step * (AxiAddrWidth'(len_q) + AxiAddrWidth'(1));
    addr_incr = addr_q + step;
    case (burst_q)
      BurstFixed: addr_next = addr_q;
      BurstWrap:  addr_next = (addr_q & ~(bound - AxiAddrWidth'(1))) |
                              (addr_incr & (bound - AxiAddrWidth'(1)));
      default:    addr_next = addr_incr;
    endcase
  end

  // Advance address and beat counter per issued beat
  always_comb begin
    addr_d     = addr_q;
    beat_cnt_d = beat_cnt_q;
    if (issue) begin
      addr_d = addr_next;
      if (beat_cnt_q != 8'd0) beat_cnt_d = beat_cnt_q - 8'd1;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (ar_hs) state_d = StBurst;
      StBurst: if (last_issue) state_d = StDrain;
      StDrain: if (r_hs && r_last_o) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Burst context: loaded on AR handshake, walked on each issue
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      burst_err_q <= 1'b0;
    end else if (ar_hs) begin
      id_q        <= ar_id_i;
      addr_q      <= ar_addr_i;
      len_q       <= ar_len_i;
      beat_cnt_q  <= ar_len_i;
      size_q      <= ar_size_i;
      burst_q     <= ar_burst_i;
      burst_err_q <= ar_err;
    end else begin
      addr_q     <= addr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Track the beat whose SRAM read completes in the next cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      infl_q      <= 1'b0;
      infl_err_q  <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      infl_q      <= issue;
      infl_err_q  <= beat_err;
      infl_last_q <= last_issue;
    end
  end

  // R head: buffered beat first; an empty buffer passes the arriving beat
  // straight through, and a stalled arriving beat is captured so it holds.
  assign head_fifo = (fifo_cnt_q != 2'd0);
  assign beat_data = infl_err_q ? '0 : mem_rdata_i;
  assign r_valid_o = head_fifo || infl_q;
  assign r_hs      = r_valid_o && r_ready_i;
  assign push      = infl_q && (head_fifo || !r_ready_i);
  assign pop       = r_hs && head_fifo;
  assign fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    r_id_o   = '0;
    r_data_o = '0;
    r_resp_o = RespOkay;
    r_last_o = 1'b0;
    if (head_fifo) begin
      r_id_o   = id_q;
      r_data_o = fifo_data_q[rd_ptr_q];
      r_resp_o = fifo_err_q[rd_ptr_q] ? RespSlvErr : RespOkay;
      r_last_o = fifo_last_q[rd_ptr_q];
    end else if (infl_q) begin
      r_id_o   = id_q;
      r_data_o = beat_data;
      r_resp_o = infl_err_q ? RespSlvErr : RespOkay;
      r_last_o = infl_last_q;
    end
  end

  // R buffer storage and pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) fifo_data_q[i] <= '0;
      fifo_err_q  <= '0;
      fifo_last_q <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      fifo_cnt_q  <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= beat_data;
        fifo_err_q[wr_ptr_q]  <= infl_err_q;
        fifo_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Bench for axi_rd_responder: SRAM model, AR driver, R/SRAM-port scoreboard
// fed by a burst-level reference model, directed cases then random bursts.
module tb_axi_rd_responder;

  localparam int          IW    = 4;
  localparam int          AW    = 64;
  localparam int          DW    = 64;
  localparam int          WORDS = 4096;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] WIN_BYTES = 64'(WORDS) * 64'd8;

  // Clock / reset
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic          ar_valid_i, ar_ready_o;
  logic [IW-1:0] ar_id_i;
  logic [AW-1:0] ar_addr_i;
  logic [7:0]    ar_len_i;
  logic [2:0]    ar_size_i;
  logic [1:0]    ar_burst_i;
  logic          r_valid_o, r_ready_i;
  logic [IW-1:0] r_id_o;
  logic [DW-1:0] r_data_o;
  logic [1:0]    r_resp_o;
  logic          r_last_o;
  logic          mem_req_o;
  logic [11:0]   mem_addr_o;
  logic [DW-1:0] mem_rdata_i;

  axi_rd_responder dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ar_valid_i  (ar_valid_i),
    .ar_ready_o  (ar_ready_o),
    .ar_id_i     (ar_id_i),
    .ar_addr_i   (ar_addr_i),
    .ar_len_i    (ar_len_i),
    .ar_size_i   (ar_size_i),
    .ar_burst_i  (ar_burst_i),
    .r_valid_o   (r_valid_o),
    .r_ready_i   (r_ready_i),
    .r_id_o      (r_id_o),
    .r_data_o    (r_data_o),
    .r_resp_o    (r_resp_o),
    .r_last_o    (r_last_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // SRAM contents and scoreboard queues
  logic [DW-1:0] mem [WORDS];
  logic [DW-1:0] exp_q[$];
  logic [6:0]    exp_meta_q[$];   // {id, resp, last}
  logic [11:0]   exp_maddr_q[$];

  int n_cmp = 0;
  int n_mis = 0;
  int rr_mode = 0;
  int hs_total = 0;
  int reqs_out = 0;
  int ok_hs = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_win(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < WIN_BYTES);
  endfunction

  // Reference model: expand one AR into its beats using the address rules
  task automatic model_burst(input logic [3:0] id, input logic [63:0] addr,
                             input int len, input int size, input int burst);
    logic [63:0] step, bound, blk, a, d;
    bit berr, err;
    step  = 64'd1 << size;
    bound = step * 64'(len + 1);
    berr  = (size > 3) || (burst == 3) ||
            (burst == 2 && !(len inside {1, 3, 7, 15})) || !in_win(addr);
    blk   = addr - (addr % bound);
    for (int i = 0; i <= len; i++) begin
      if (burst == 0)      a = addr;
      else if (burst == 2) a = blk + (((addr - blk) + 64'(i) * step) % bound);
      else                 a = addr + 64'(i) * step;
      err = berr || (burst == 1 && !in_win(a));
      d = '0;
      if (!err) begin
        d = mem[int'((a - BASE) >> 3)];
        exp_maddr_q.push_back(12'((a - BASE) >> 3));
      end
      exp_q.push_back(d);
      exp_meta_q.push_back({id, (err ? 2'b10 : 2'b00), (i == len)});
    end
  endtask

  // SRAM: one-cycle read latency, junk on idle cycles
  always @(posedge clk_i) begin
    if (mem_req_o) mem_rdata_i <= mem[mem_addr_o];
    else           mem_rdata_i <= {$urandom, $urandom};
  end

  // R ready driver: 0 = always ready, 1 = random, 2 = pattern 1,0,0
  int rr_ph = 0;
  initial begin
    r_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      case (rr_mode)
        1:       r_ready_i = 1'($urandom_range(0, 1));
        2:       r_ready_i = (rr_ph == 0);
        default: r_ready_i = 1'b1;
      endcase
      rr_ph = (rr_ph + 1) % 3;
    end
  end

  // Scoreboard monitor, sampled on the falling edge
  logic          stall;
  logic [DW-1:0] st_data;
  logic [6:0]    st_meta;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      stall    = 1'b0;
      reqs_out = 0;
      ok_hs    = 0;
    end else begin
      if (stall) begin
        check("stall_valid", 64'(r_valid_o), 64'd1);
        check("stall_data", r_data_o, st_data);
        check("stall_meta", 64'({r_id_o, r_resp_o, r_last_o}), 64'(st_meta));
      end
      if (mem_req_o) begin
        reqs_out++;
        if (exp_maddr_q.size() == 0) check("req_unexpected", 64'd1, 64'd0);
        else check("mem_addr", 64'(mem_addr_o), 64'(exp_maddr_q.pop_front()));
        check("outstanding", 64'((reqs_out - ok_hs) <= 2), 64'd1);
      end
      if (r_valid_o && r_ready_i) begin
        hs_total++;
        if (r_resp_o == 2'b00) ok_hs++;
        if (exp_q.size() == 0) check("r_unexpected", 64'd1, 64'd0);
        else begin
          check("r_data", r_data_o, exp_q.pop_front());
          check("r_meta", 64'({r_id_o, r_resp_o, r_last_o}), 64'(exp_meta_q.pop_front()));
        end
      end
      stall   = r_valid_o && !r_ready_i;
      st_data = r_data_o;
      st_meta = {r_id_o, r_resp_o, r_last_o};
    end
  end

  // AR driver: returns #1 after the handshake edge (first cycle after AR)
  task automatic do_ar(input logic [3:0] id, input logic [63:0] addr,
                       input int len, input int size, input int burst);
    int t = 0;
    @(negedge clk_i);
    while (!ar_ready_o && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    check("ar_ready_wait", 64'(ar_ready_o), 64'd1);
    ar_valid_i = 1'b1;
    ar_id_i    = id;
    ar_addr_i  = addr;
    ar_len_i   = 8'(len);
    ar_size_i  = 3'(size);
    ar_burst_i = 2'(burst);
    model_burst(id, addr, len, size, burst);
    @(posedge clk_i);
    #1;
    ar_valid_i = 1'b0;
    ar_addr_i  = {$urandom, $urandom};
    ar_len_i   = 8'($urandom);
    ar_size_i  = 3'($urandom);
    ar_burst_i = 2'($urandom);
    ar_id_i    = 4'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || !ar_ready_o) && t < 400) begin
      @(negedge clk_i);
      #1;
      t++;
    end
    check("drain_timeout", 64'(t < 400), 64'd1);
    check("leftover_req", 64'(exp_maddr_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = {$urandom, $urandom};
    mem[2] = 64'hDEAD_BEEF_0123_4567;
    ar_valid_i = 1'b0; ar_id_i = '0; ar_addr_i = '0;
    ar_len_i = '0; ar_size_i = '0; ar_burst_i = '0;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ar_ready", 64'(ar_ready_o), 64'd1);
    check("rst_r_valid", 64'(r_valid_o), 64'd0);
    check("rst_r_last", 64'(r_last_o), 64'd0);
    check("rst_r_resp", 64'(r_resp_o), 64'd0);
    check("rst_r_id", 64'(r_id_o), 64'd0);
    check("rst_r_data", r_data_o, 64'd0);
    check("rst_mem_req", 64'(mem_req_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // INCR single beat: request in N+1, data in N+2
    do_ar(4'h3, BASE + 64'h10, 0, 3, 1);
    @(negedge clk_i);
    check("t1_req", 64'(mem_req_o), 64'd1);
    check("t1_maddr", 64'(mem_addr_o), 64'd2);
    check("t1_valid_n1", 64'(r_valid_o), 64'd0);
    @(negedge clk_i);
    check("t1_valid_n2", 64'(r_valid_o), 64'd1);
    check("t1_data", r_data_o, 64'hDEAD_BEEF_0123_4567);
    check("t1_last", 64'(r_last_o), 64'd1);
    wait_idle();

    // INCR 4 beats back to back, one idle cycle after
    do_ar(4'h5, BASE, 3, 3, 1);
    @(negedge clk_i);
    check("t2_req", 64'(mem_req_o), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("t2_valid", 64'(r_valid_o), 64'd1);
      check("t2_ar_busy", 64'(ar_ready_o), 64'd0);
    end
    @(negedge clk_i);
    check("t2_ar_back", 64'(ar_ready_o), 64'd1);
    check("t2_valid_end", 64'(r_valid_o), 64'd0);
    wait_idle();

    // Backpressure 1,0,0 and AR traffic while busy (must be ignored)
    rr_mode = 2;
    do_ar(4'h6, BASE, 3, 3, 1);
    ar_valid_i = 1'b1; ar_addr_i = BASE + 64'h800; ar_len_i = 8'd0;
    ar_size_i = 3'd3; ar_burst_i = 2'b01;
    repeat (3) @(posedge clk_i);
    #1;
    ar_valid_i = 1'b0;
    wait_idle();
    rr_mode = 0;

    // WRAP: word sequence 3,0,1,2
    do_ar(4'h7, BASE + 64'h18, 3, 3, 2);
    wait_idle();

    // Error bursts
    do_ar(4'h8, 64'h0, 1, 3, 1);
    wait_idle();
    do_ar(4'h9, BASE, 1, 4, 1);
    wait_idle();
    do_ar(4'hA, BASE + WIN_BYTES - 64'd8, 1, 3, 1);
    wait_idle();

    // Reset during beat 2 of 8
    begin
      int h0, t;
      h0 = hs_total;
      t = 0;
      do_ar(4'hB, BASE + 64'h40, 7, 3, 1);
      while (hs_total < h0 + 2 && t < 50) begin
        @(negedge clk_i);
        #1;
        t++;
      end
      check("t6_reach_beat2", 64'(hs_total - h0), 64'd2);
      rst_ni = 1'b0;
      #1;
      check("t6_valid_rst", 64'(r_valid_o), 64'd0);
      check("t6_ar_ready_rst", 64'(ar_ready_o), 64'd1);
      check("t6_req_rst", 64'(mem_req_o), 64'd0);
      exp_q.delete();
      exp_meta_q.delete();
      exp_maddr_q.delete();
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);
      check("t6_no_beats", 64'(r_valid_o), 64'd0);
      do_ar(4'hC, BASE + 64'h100, 1, 3, 1);
      wait_idle();
    end

    // Random bursts
    for (int n = 0; n < 60; n++) begin
      logic [63:0] a;
      int b, l, s, r, off;
      rr_mode = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      b = $urandom_range(0, 9);
      b = (b < 2) ? 0 : (b < 6) ? 1 : (b < 9) ? 2 : 3;
      s = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      if (b == 2 && $urandom_range(0, 5) != 0) begin
        l = $urandom_range(0, 3);
        l = (1 << (l + 1)) - 1;
      end else begin
        l = $urandom_range(0, 15);
      end
      off = (s <= 3) ? (($urandom_range(0, 7) >> s) << s) : 0;
      if (r == 0)      a = 64'($urandom_range(0, 32'h7FFF_FFF8));
      else if (r == 1) a = BASE + WIN_BYTES - 64'($urandom_range(1, 8)) * 64'd8;
      else             a = BASE + (64'($urandom_range(0, WORDS - 1)) << 3) + 64'(off);
      do_ar(4'($urandom), a, l, s, b);
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
